// File: rtl/counter_display_scan.sv
// -----------------------------------------------------------------------------
// counter_display_scan
//
// Display back-end for the stopwatch. Takes the binary minute, second and
// hundredths fields and drives a 6-digit multiplexed 7-segment display laid
// out as MM.SS.hh (anode bit 5 is the leftmost digit).
//
// A snapshot of the three fields is taken once per scan frame, at the moment
// the scan wraps from digit 5 back to digit 0. Because of this, one frame can
// never show values taken at different times. Hundredths above 99 are stored
// as 99. Minutes and seconds are stored as they arrive, so 60..63 appear on
// the display unchanged.
//
// Parameters:
//   SCAN_DIV       clk_core cycles spent on each digit slot (>= 2)
//   SEG_ACTIVE_LOW 1 = seg_o/dp_o/an_o active low (common anode), 0 = active high
//
// Ports:
//   clk_core  in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   min_i     in   [5:0] minutes, binary
//   sec_i     in   [5:0] seconds, binary
//   ms_10_i   in   [6:0] hundredths, binary
//   seg_o     out  [6:0] segments {g,f,e,d,c,b,a}, registered
//   dp_o      out  decimal point of the selected digit, registered
//   an_o      out  [5:0] digit enables (one-hot when active), registered
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - when defined, the minutes-tens slot is blanked
//   (segments and dp off) if that digit is zero. Its anode still pulses, so
//   scan timing and brightness stay the same.
// -----------------------------------------------------------------------------
module counter_display_scan #(
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic       clk_core,
   input  logic       rst,
   input  logic [5:0] min_i,
   input  logic [5:0] sec_i,
   input  logic [6:0] ms_10_i,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic [5:0] an_o
);

   localparam int          CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic        POL      = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   // Tens digit of a value 0..99.
   function automatic logic [3:0] bcd_tens(input logic [6:0] v);
      logic [6:0] q;
      q = v / 7'd10;
      return q[3:0];
   endfunction

   // Units digit of a value 0..99.
   function automatic logic [3:0] bcd_units(input logic [6:0] v);
      logic [6:0] r;
      r = v % 7'd10;
      return r[3:0];
   endfunction

   // Active-high 7-segment pattern {g,f,e,d,c,b,a}; non-decimal codes are dark.
   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]       dig_q, dig_d;
   logic [5:0]       min_s_q, min_s_d;
   logic [5:0]       sec_s_q, sec_s_d;
   logic [6:0]       ms_s_q, ms_s_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [5:0]       an_q, an_d;

   logic             tick_s;
   logic [3:0]       nib_s;
   logic             blank_s;
   logic [6:0]       seg_act_s;
   logic [5:0]       an_act_s;
   logic             dp_act_s;

   // Scan divider, digit index and frame-boundary snapshot.
   always_comb begin
      tick_s    = (div_cnt_q == CNT_LAST);
      div_cnt_d = div_cnt_q;
      dig_d     = dig_q;
      min_s_d   = min_s_q;
      sec_s_d   = sec_s_q;
      ms_s_d    = ms_s_q;
      if (tick_s) begin
         div_cnt_d = '0;
         if (dig_q == 3'd5) begin
            dig_d   = 3'd0;
            min_s_d = min_i;
            sec_s_d = sec_i;
            ms_s_d  = (ms_10_i > 7'd99) ? 7'd99 : ms_10_i;
         end else begin
            dig_d = dig_q + 3'd1;
         end
      end else begin
         div_cnt_d = div_cnt_q + CNT_W'(1);
      end
   end

   // Select the BCD digit for the current slot and build next output values.
   always_comb begin
      blank_s = 1'b0;
      case (dig_q)
         3'd0:    nib_s = bcd_units(ms_s_q);
         3'd1:    nib_s = bcd_tens(ms_s_q);
         3'd2:    nib_s = bcd_units({1'b0, sec_s_q});
         3'd3:    nib_s = bcd_tens({1'b0, sec_s_q});
         3'd4:    nib_s = bcd_units({1'b0, min_s_q});
         3'd5: begin
            nib_s = bcd_tens({1'b0, min_s_q});
`ifdef LEADING_ZERO_BLANK_EN
            blank_s = (nib_s == 4'd0);
`else
            blank_s = 1'b0;
`endif
         end
         default: nib_s = 4'hF;
      endcase
      if (blank_s) begin
         seg_act_s = 7'b0000000;
         dp_act_s  = 1'b0;
      end else begin
         seg_act_s = seg_enc(nib_s);
         dp_act_s  = (dig_q == 3'd2) || (dig_q == 3'd4);
      end
      an_act_s = 6'b000001 << dig_q;
      // XOR with the polarity flag turns active-high patterns into pin levels.
      seg_d = seg_act_s ^ {7{POL}};
      dp_d  = dp_act_s ^ POL;
      an_d  = an_act_s ^ {6{POL}};
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_core) begin
      if (rst) begin
         div_cnt_q <= '0;
         dig_q     <= 3'd0;
         min_s_q   <= 6'd0;
         sec_s_q   <= 6'd0;
         ms_s_q    <= 7'd0;
         seg_q     <= {7{POL}};
         dp_q      <= POL;
         an_q      <= {6{POL}};
      end else begin
         div_cnt_q <= div_cnt_d;
         dig_q     <= dig_d;
         min_s_q   <= min_s_d;
         sec_s_q   <= sec_s_d;
         ms_s_q    <= ms_s_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign seg_o = seg_q;
   assign dp_o  = dp_q;
   assign an_o  = an_q;

endmodule

// File: tb/tb_counter_display_scan.sv
`timescale 1ns/1ps
module tb_counter_display_scan;

   logic       clk_core = 1'b0;
   logic       rst      = 1'b1;
   logic [5:0] min_i    = 6'd12;
   logic [5:0] sec_i    = 6'd34;
   logic [6:0] ms_10_i  = 7'd56;
   logic [6:0] seg_o;
   logic       dp_o;
   logic [5:0] an_o;

   int vectors     = 0;
   int miscompares = 0;

   counter_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
      .clk_core (clk_core),
      .rst      (rst),
      .min_i    (min_i),
      .sec_i    (sec_i),
      .ms_10_i  (ms_10_i),
      .seg_o    (seg_o),
      .dp_o     (dp_o),
      .an_o     (an_o)
   );

   always #5 clk_core = ~clk_core;

   localparam int BLANK = 10;

   // Minutes-tens slot when that digit is zero.
`ifdef LEADING_ZERO_BLANK_EN
   localparam int LZ = BLANK;
`else
   localparam int LZ = 0;
`endif

   // Hand-written active-low segment patterns {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_al(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic edge_wait();
      @(posedge clk_core);
      #1;
   endtask

   task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // n edges of digit slot d showing value v; outputs checked after each edge.
   task automatic slot_n(input string tag, input int d, input int v, input int n);
      logic [5:0] an_exp;
      logic       dp_exp;
      an_exp = ~(6'b000001 << d);
      dp_exp = ((d == 2 || d == 4) && v != BLANK) ? 1'b0 : 1'b1;
      for (int i = 0; i < n; i++) begin
         edge_wait();
         chk6({tag, "_an"}, an_o, an_exp);
         chk7({tag, "_seg"}, seg_o, seg_al(v));
         chk1({tag, "_dp"}, dp_o, dp_exp);
      end
   endtask

   task automatic slot(input string tag, input int d, input int v);
      slot_n(tag, d, v, 4);
   endtask

   task automatic reset_check(input string tag);
      edge_wait();
      chk6({tag, "_an"}, an_o, 6'b111111);
      chk7({tag, "_seg"}, seg_o, 7'b1111111);
      chk1({tag, "_dp"}, dp_o, 1'b1);
   endtask

   initial begin
      // Three reset cycles with min=12 on the inputs.
      rst = 1'b1;
      reset_check("rst0");
      reset_check("rst1");
      reset_check("rst2");
      rst = 1'b0;

      // Frame 1: zero shadows.
      slot("f1d0", 0, 0);
      slot("f1d1", 1, 0);
      slot("f1d2", 2, 0);
      slot("f1d3", 3, 0);
      slot("f1d4", 4, 0);
      slot("f1d5", 5, LZ);

      // Frame 2: 12:34.56 captured at the end of frame 1.
      slot("f2d0", 0, 6);
      slot("f2d1", 1, 5);
      slot("f2d2", 2, 4);
      slot("f2d3", 3, 3);
      slot("f2d4", 4, 2);
      ms_10_i = 7'd120;
      slot("f2d5", 5, 1);

      // Frame 3: ms clamped to 99; sec changes mid-frame at dig 2.
      slot("f3d0", 0, 9);
      slot("f3d1", 1, 9);
      slot_n("f3d2a", 2, 4, 1);
      sec_i = 6'd35;
      slot_n("f3d2b", 2, 4, 3);
      slot("f3d3", 3, 3);
      slot("f3d4", 4, 2);
      slot("f3d5", 5, 1);

      // Frame 4: new seconds value visible; reset pulse during dig 3.
      slot("f4d0", 0, 9);
      slot("f4d1", 1, 9);
      slot("f4d2", 2, 5);
      slot_n("f4d3", 3, 3, 1);
      rst = 1'b1;
      reset_check("rst_mid");
      rst = 1'b0;
      min_i = 6'd7;

      // Frame 5: back to zero shadows, divider restarted.
      slot("f5d0", 0, 0);
      slot("f5d1", 1, 0);
      slot("f5d2", 2, 0);
      slot("f5d3", 3, 0);
      slot("f5d4", 4, 0);
      slot("f5d5", 5, LZ);

      // Frame 6: 07:35.99 with leading-zero handling on dig 5.
      slot("f6d0", 0, 9);
      slot("f6d1", 1, 9);
      slot("f6d2", 2, 5);
      slot("f6d3", 3, 3);
      slot("f6d4", 4, 7);
      slot("f6d5", 5, LZ);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
